// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - run controller gating mips core reset/clock-enable with step, breakpoint and cycle budget
module cpu_run_ctrl #(
    parameter int RST_HOLD   = 4,
    parameter int CNT_W      = 32,
    parameter int MAX_CYCLES = 1000,
    parameter int PC_W       = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_step_mode,
    input  logic             i_step,
    input  logic [PC_W-1:0]  i_pc,
    input  logic             i_bp_en,
    input  logic [PC_W-1:0]  i_bp_addr,
    input  logic             i_halt_req,
    output logic             o_core_rst,
    output logic             o_core_en,
    output logic [2:0]       o_state,
    output logic [CNT_W-1:0] o_cycle_cnt,
    output logic             o_done,
    output logic             o_timeout
);

    typedef enum logic [2:0] {
        S_HOLD    = 3'd0,
        S_IDLE    = 3'd1,
        S_RUN     = 3'd2,
        S_STEP    = 3'd3,
        S_HALTED  = 3'd4,
        S_TIMEOUT = 3'd5
    } state_t;

    localparam int HW        = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam int HOLD_LAST = (RST_HOLD > 1) ? RST_HOLD - 1 : 0;
    localparam int MAX_M1    = (MAX_CYCLES > 0) ? MAX_CYCLES - 1 : 0;
    localparam logic [HW-1:0]    LP_HOLD_LAST = HW'(HOLD_LAST);
    localparam logic [CNT_W-1:0] LP_MAX_M1    = CNT_W'(MAX_M1);

    state_t           r_state;
    logic [HW-1:0]    r_hold_cnt;
    logic [CNT_W-1:0] r_cycle_cnt;
    logic             r_done;
    logic             r_timeout;

    state_t           w_state_nxt;
    logic [HW-1:0]    w_hold_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_done_nxt;
    logic             w_timeout_nxt;
    logic             w_stop;
    logic             w_core_en;
    logic             w_budget_hit;

    assign w_stop    = i_halt_req | (i_bp_en & (i_pc == i_bp_addr));
    // Stop blocks the instruction at pc in the same cycle, so a stopped cycle is never counted.
    assign w_core_en = ((r_state == S_RUN) | ((r_state == S_STEP) & i_step)) & ~w_stop;
    assign w_budget_hit = (MAX_CYCLES != 0) & w_core_en & (r_cycle_cnt == LP_MAX_M1);

    always_comb begin
        w_state_nxt   = r_state;
        w_hold_nxt    = r_hold_cnt;
        w_cnt_nxt     = r_cycle_cnt;
        w_done_nxt    = r_done;
        w_timeout_nxt = r_timeout;

        if (w_core_en && (r_cycle_cnt != {CNT_W{1'b1}})) begin
            w_cnt_nxt = r_cycle_cnt + 1'b1;
        end

        case (r_state)
            S_HOLD: begin
                if (r_hold_cnt == LP_HOLD_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_hold_nxt  = '0;
                end else begin
                    w_hold_nxt = r_hold_cnt + 1'b1;
                end
            end
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = i_step_mode ? S_STEP : S_RUN;
                end
            end
            S_RUN: begin
                if (w_stop) begin
                    w_state_nxt = S_HALTED;
                    w_done_nxt  = 1'b1;
                end else if (w_budget_hit) begin
                    w_state_nxt   = S_TIMEOUT;
                    w_timeout_nxt = 1'b1;
                end else if (i_step_mode) begin
                    w_state_nxt = S_STEP;
                end
            end
            S_STEP: begin
                if (w_stop && i_step) begin
                    w_state_nxt = S_HALTED;
                    w_done_nxt  = 1'b1;
                end else if (w_budget_hit) begin
                    w_state_nxt   = S_TIMEOUT;
                    w_timeout_nxt = 1'b1;
                end else if (!i_step_mode) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_HALTED, S_TIMEOUT: begin
                if (i_start) begin
                    w_state_nxt   = S_HOLD;
                    w_hold_nxt    = '0;
                    w_cnt_nxt     = '0;
                    w_done_nxt    = 1'b0;
                    w_timeout_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_HOLD;
                w_hold_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_HOLD;
            r_hold_cnt  <= '0;
            r_cycle_cnt <= '0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_hold_cnt  <= w_hold_nxt;
            r_cycle_cnt <= w_cnt_nxt;
            r_done      <= w_done_nxt;
            r_timeout   <= w_timeout_nxt;
        end
    end

    assign o_core_rst  = (r_state == S_HOLD);
    assign o_core_en   = w_core_en;
    assign o_state     = r_state;
    assign o_cycle_cnt = r_cycle_cnt;
    assign o_done      = r_done;
    assign o_timeout   = r_timeout;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - directed bench for cpu_run_ctrl
module tb_cpu_run_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        step_mode;
    logic        step;
    logic [31:0] pc;
    logic        bp_en;
    logic [31:0] bp_addr;
    logic        halt_req;

    logic        a_core_rst, a_core_en, a_done, a_timeout;
    logic [2:0]  a_state;
    logic [31:0] a_cnt;

    logic        b_step_mode = 1'b0;
    logic        b_bp_en     = 1'b0;
    logic        b_halt_req  = 1'b0;
    logic        b_core_rst, b_core_en, b_done, b_timeout;
    logic [2:0]  b_state;
    logic [3:0]  b_cnt;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cpu_run_ctrl #(.RST_HOLD(4), .CNT_W(32), .MAX_CYCLES(10), .PC_W(32)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_step_mode(step_mode),
        .i_step(step), .i_pc(pc), .i_bp_en(bp_en), .i_bp_addr(bp_addr),
        .i_halt_req(halt_req), .o_core_rst(a_core_rst), .o_core_en(a_core_en),
        .o_state(a_state), .o_cycle_cnt(a_cnt), .o_done(a_done), .o_timeout(a_timeout)
    );

    cpu_run_ctrl #(.RST_HOLD(4), .CNT_W(4), .MAX_CYCLES(0), .PC_W(32)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_step_mode(b_step_mode),
        .i_step(step), .i_pc(pc), .i_bp_en(b_bp_en), .i_bp_addr(bp_addr),
        .i_halt_req(b_halt_req), .o_core_rst(b_core_rst), .o_core_en(b_core_en),
        .o_state(b_state), .o_cycle_cnt(b_cnt), .o_done(b_done), .o_timeout(b_timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; step_mode = 1'b0; step = 1'b0;
        pc = 32'h3000; bp_en = 1'b0; bp_addr = 32'h3010; halt_req = 1'b0;

        // reset values and hold window
        #2;
        chk("rst_state", {29'd0, a_state}, 32'd0);
        chk("rst_core_rst", {31'd0, a_core_rst}, 32'd1);
        chk("rst_core_en", {31'd0, a_core_en}, 32'd0);
        chk("rst_cnt", a_cnt, 32'd0);
        chk("rst_flags", {30'd0, a_done, a_timeout}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            tick(1);
            chk("hold_core_rst", {31'd0, a_core_rst}, 32'd1);
        end
        tick(1);
        chk("idle_core_rst", {31'd0, a_core_rst}, 32'd0);
        chk("idle_state", {29'd0, a_state}, 32'd1);
        chk("idle_core_en", {31'd0, a_core_en}, 32'd0);
        chk("idle_cnt", a_cnt, 32'd0);

        // free run to breakpoint at 0x3010
        bp_en = 1'b1; start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("run_state", {29'd0, a_state}, 32'd2);
        for (int k = 0; k < 4; k++) begin
            pc = 32'h3000 + 32'(4 * k);
            #1;
            chk("run_core_en", {31'd0, a_core_en}, 32'd1);
            tick(1);
        end
        pc = 32'h3010;
        #1;
        chk("bp_core_en", {31'd0, a_core_en}, 32'd0);
        tick(1);
        chk("bp_state", {29'd0, a_state}, 32'd4);
        chk("bp_done", {31'd0, a_done}, 32'd1);
        chk("bp_cnt", a_cnt, 32'd4);

        // restart into single-step
        bp_en = 1'b0; start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("restart_state", {29'd0, a_state}, 32'd0);
        chk("restart_cnt", a_cnt, 32'd0);
        chk("restart_done", {31'd0, a_done}, 32'd0);
        tick(4);
        chk("restart_idle", {29'd0, a_state}, 32'd1);
        step_mode = 1'b1; start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("step_state", {29'd0, a_state}, 32'd3);
        for (int p = 0; p < 3; p++) begin
            chk("step_gap_en", {31'd0, a_core_en}, 32'd0);
            step = 1'b1;
            #1;
            chk("step_pulse_en", {31'd0, a_core_en}, 32'd1);
            tick(1);
            step = 1'b0;
            tick(4);
        end
        chk("step_cnt", a_cnt, 32'd3);
        chk("step_stay", {29'd0, a_state}, 32'd3);

        // free run into the budget of 10
        step_mode = 1'b0;
        tick(1);
        chk("to_run_state", {29'd0, a_state}, 32'd2);
        chk("to_run_cnt", a_cnt, 32'd3);
        tick(6);
        chk("pre_to_cnt", a_cnt, 32'd9);
        chk("pre_to_state", {29'd0, a_state}, 32'd2);
        tick(1);
        chk("to_state", {29'd0, a_state}, 32'd5);
        chk("to_flag", {31'd0, a_timeout}, 32'd1);
        chk("to_cnt", a_cnt, 32'd10);
        chk("to_core_en", {31'd0, a_core_en}, 32'd0);
        start = 1'b1;
        tick(1);
        chk("to_restart_state", {29'd0, a_state}, 32'd0);
        chk("to_restart_cnt", a_cnt, 32'd0);
        chk("to_restart_flag", {31'd0, a_timeout}, 32'd0);

        // halt_req on the final budgeted cycle beats timeout
        start = 1'b0;
        tick(4);
        start = 1'b1;
        tick(2);
        chk("start_ignored_run", {29'd0, a_state}, 32'd2);
        start = 1'b0;
        tick(8);
        chk("h_cnt", a_cnt, 32'd9);
        halt_req = 1'b1;
        #1;
        chk("h_core_en", {31'd0, a_core_en}, 32'd0);
        tick(1);
        halt_req = 1'b0;
        chk("h_state", {29'd0, a_state}, 32'd4);
        chk("h_done", {31'd0, a_done}, 32'd1);
        chk("h_timeout", {31'd0, a_timeout}, 32'd0);
        chk("h_cnt_final", a_cnt, 32'd9);

        // asynchronous reset mid-run
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(4);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(3);
        chk("ar_pre_cnt", a_cnt, 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_core_rst", {31'd0, a_core_rst}, 32'd1);
        chk("ar_core_en", {31'd0, a_core_en}, 32'd0);
        chk("ar_cnt", a_cnt, 32'd0);
        chk("ar_state", {29'd0, a_state}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 4-bit counter with unlimited budget saturates
        tick(4);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("sat_run_state", {29'd0, b_state}, 32'd2);
        tick(14);
        chk("sat_cnt14", {28'd0, b_cnt}, 32'd14);
        tick(1);
        chk("sat_cnt15", {28'd0, b_cnt}, 32'd15);
        tick(5);
        chk("sat_hold", {28'd0, b_cnt}, 32'd15);
        chk("sat_state", {29'd0, b_state}, 32'd2);
        chk("sat_core_en", {31'd0, b_core_en}, 32'd1);
        chk("sat_timeout", {31'd0, b_timeout}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
